// File: rtl/timer_pkg.sv
// Shared types for the multi-channel countdown timer.
//   timer_state_t  - per-channel run state
//   channel_reg_t  - per-channel register record (count, reload, mode, state)
package timer_pkg;

  // Width of the count/reload fields in the channel record.
  localparam int unsigned TMR_COUNT_W = 4;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_RUN    = 2'd1,
    T_PAUSED = 2'd2
  } timer_state_t;

  typedef struct packed {
    logic [TMR_COUNT_W-1:0] count;
    logic [TMR_COUNT_W-1:0] reload;
    logic                   mode;   // 1: periodic auto-reload, 0: one-shot
    timer_state_t           state;
  } channel_reg_t;

  localparam channel_reg_t CHANNEL_RESET = '{
    count:  '0,
    reload: '0,
    mode:   1'b0,
    state:  T_IDLE
  };

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick prescaler shared by all timer channels.
//   clk_104mhz in  system clock
//   reset      in  asynchronous active-high reset
//   tick_c     out one-cycle pulse every TICK_DIV cycles (decoded from the counter)
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 52_000_000
) (
  input  logic clk_104mhz,
  input  logic reset,
  output logic tick_c
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;

  // Counts 0..TICK_DIV-1 and wraps; never restarted by channel activity.
  always_ff @(posedge clk_104mhz or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick_c = (div_q == DIV_LAST);

endmodule

// File: rtl/multi_timer.sv
// Multi-channel countdown timer with one shared tick prescaler.
//   clk_104mhz    in  system clock
//   reset         in  asynchronous active-high reset
//   start         in  per-channel load+run strobe
//   abort         in  per-channel cancel strobe
//   pause         in  per-channel freeze level
//   periodic      in  per-channel mode, sampled at start
//   value         in  per-channel load values, channel i at [i*COUNT_W +: COUNT_W]
//   countdown_out out per-channel current count, same packing
//   expired       out per-channel one-cycle pulse on reaching 0
//   done          out per-channel sticky completion flag
//   busy          out per-channel running or paused
//   irq           out OR of expired, one cycle later
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned COUNT_W  = TMR_COUNT_W,
  parameter int unsigned TICK_DIV = 52_000_000
) (
  input  logic                      clk_104mhz,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         abort,
  input  logic [NUM_CH-1:0]         pause,
  input  logic [NUM_CH-1:0]         periodic,
  input  logic [NUM_CH*COUNT_W-1:0] value,
  output logic [NUM_CH*COUNT_W-1:0] countdown_out,
  output logic [NUM_CH-1:0]         expired,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH-1:0]         busy,
  output logic                      irq
);

  logic tick_c;
  logic irq_q;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_104mhz (clk_104mhz),
    .reset      (reset),
    .tick_c     (tick_c)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    channel_reg_t       ch_q, ch_d;
    logic               exp_q, exp_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [COUNT_W-1:0] load_val;

    assign load_val = value[i*COUNT_W +: COUNT_W];

    // Channel register bank.
    always_ff @(posedge clk_104mhz or posedge reset) begin
      if (reset) begin
        ch_q   <= CHANNEL_RESET;
        exp_q  <= 1'b0;
        done_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        ch_q   <= ch_d;
        exp_q  <= exp_d;
        done_q <= done_d;
        busy_q <= busy_d;
      end
    end

    // Next-state: start > abort > pause > tick.
    always_comb begin
      ch_d   = ch_q;
      exp_d  = 1'b0;
      done_d = done_q;

      if (start[i]) begin
        ch_d.reload = load_val;
        ch_d.mode   = periodic[i];
        if (load_val == '0) begin
          // Zero load expires immediately without ever running.
          ch_d.state = T_IDLE;
          ch_d.count = '0;
          exp_d      = 1'b1;
          done_d     = 1'b1;
        end else begin
          ch_d.state = T_RUN;
          ch_d.count = load_val;
          done_d     = 1'b0;
        end
      end else if (abort[i]) begin
        ch_d.state = T_IDLE;
        ch_d.count = '0;
        done_d     = 1'b0;
      end else begin
        unique case (ch_q.state)
          T_RUN: begin
            if (pause[i]) begin
              ch_d.state = T_PAUSED;
            end else if (tick_c) begin
              if (ch_q.count > COUNT_W'(1)) begin
                ch_d.count = ch_q.count - COUNT_W'(1);
              end else begin
                exp_d  = 1'b1;
                done_d = 1'b1;
                if (ch_q.mode) begin
                  ch_d.count = ch_q.reload;
                end else begin
                  ch_d.state = T_IDLE;
                  ch_d.count = '0;
                end
              end
            end
          end
          T_PAUSED: begin
            // Resume cycle ignores any coincident tick; count stays held.
            if (!pause[i]) begin
              ch_d.state = T_RUN;
            end
          end
          default: begin
            ch_d.state = T_IDLE;
          end
        endcase
      end

      busy_d = (ch_d.state != T_IDLE);
    end

    assign countdown_out[i*COUNT_W +: COUNT_W] = ch_q.count;
    assign expired[i] = exp_q;
    assign done[i]    = done_q;
    assign busy[i]    = busy_q;
  end

  // Aggregate interrupt, one cycle behind the expired pulses.
  always_ff @(posedge clk_104mhz or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |expired;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus random stimulus
// against a cycle-level behavioural model of the channel rules.
module tb_multi_timer;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned COUNT_W  = 4;
  localparam int unsigned TICK_DIV = 4;

  logic                      clk_104mhz = 1'b0;
  logic                      reset;
  logic [NUM_CH-1:0]         start, abort, pause, periodic;
  logic [NUM_CH*COUNT_W-1:0] value;
  logic [NUM_CH*COUNT_W-1:0] countdown_out;
  logic [NUM_CH-1:0]         expired, done, busy;
  logic                      irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int m_cnt  [NUM_CH];
  int m_rel  [NUM_CH];
  bit m_per  [NUM_CH];
  bit m_act  [NUM_CH];  // running or paused
  bit m_hold [NUM_CH];  // paused
  bit m_done [NUM_CH];
  bit m_exp  [NUM_CH];
  bit m_irq;
  int phase;

  multi_timer #(
    .NUM_CH   (NUM_CH),
    .COUNT_W  (COUNT_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk_104mhz    (clk_104mhz),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .pause         (pause),
    .periodic      (periodic),
    .value         (value),
    .countdown_out (countdown_out),
    .expired       (expired),
    .done          (done),
    .busy          (busy),
    .irq           (irq)
  );

  always #5 clk_104mhz = ~clk_104mhz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_per[i] = 0; m_act[i] = 0;
      m_hold[i] = 0; m_done[i] = 0; m_exp[i] = 0;
    end
    m_irq = 0;
    phase = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit tick;
    bit any_exp;
    tick = (phase == TICK_DIV - 1);
    any_exp = 0;
    for (int i = 0; i < NUM_CH; i++) any_exp |= m_exp[i];
    m_irq = any_exp;
    for (int i = 0; i < NUM_CH; i++) begin
      int v;
      v = int'(value[i*COUNT_W +: COUNT_W]);
      m_exp[i] = 0;
      if (start[i]) begin
        m_rel[i]  = v;
        m_per[i]  = periodic[i];
        m_hold[i] = 0;
        if (v == 0) begin
          m_act[i] = 0; m_cnt[i] = 0; m_exp[i] = 1; m_done[i] = 1;
        end else begin
          m_act[i] = 1; m_cnt[i] = v; m_done[i] = 0;
        end
      end else if (abort[i]) begin
        m_act[i] = 0; m_hold[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
      end else if (m_act[i] && m_hold[i]) begin
        if (!pause[i]) m_hold[i] = 0;
      end else if (m_act[i]) begin
        if (pause[i]) begin
          m_hold[i] = 1;
        end else if (tick) begin
          if (m_cnt[i] == 1) begin
            m_exp[i] = 1; m_done[i] = 1;
            if (m_per[i]) m_cnt[i] = m_rel[i];
            else begin m_act[i] = 0; m_cnt[i] = 0; end
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
    end
    phase = (phase + 1) % TICK_DIV;
  endtask

  task automatic compare_all();
    logic [NUM_CH*COUNT_W-1:0] ec;
    logic [NUM_CH-1:0] ee, ed, eb;
    for (int i = 0; i < NUM_CH; i++) begin
      ec[i*COUNT_W +: COUNT_W] = COUNT_W'(m_cnt[i]);
      ee[i] = m_exp[i];
      ed[i] = m_done[i];
      eb[i] = m_act[i];
    end
    check_eq("countdown_out", 32'(countdown_out), 32'(ec));
    check_eq("expired", 32'(expired), 32'(ee));
    check_eq("done", 32'(done), 32'(ed));
    check_eq("busy", 32'(busy), 32'(eb));
    check_eq("irq", 32'(irq), 32'(m_irq));
  endtask

  // Called at a negedge: apply current inputs, clock once, compare at next negedge.
  task automatic step();
    model_step();
    @(posedge clk_104mhz);
    @(negedge clk_104mhz);
    start = '0;
    abort = '0;
    compare_all();
  endtask

  task automatic set_val(input int ch, input int v);
    value[ch*COUNT_W +: COUNT_W] = COUNT_W'(v);
  endtask

  function automatic logic [COUNT_W-1:0] cnt_of(input int ch);
    return countdown_out[ch*COUNT_W +: COUNT_W];
  endfunction

  initial begin
    int pulses;
    logic [NUM_CH-1:0] cap;

    reset = 1'b1;
    start = '0; abort = '0; pause = '0; periodic = '0; value = '0;
    model_reset();
    repeat (3) @(posedge clk_104mhz);
    @(negedge clk_104mhz);
    check_eq("rst_count", 32'(countdown_out), 32'd0);
    check_eq("rst_flags", 32'({expired, done, busy, irq}), 32'd0);
    reset = 1'b0;

    // ch0 one-shot from 3.
    start[0] = 1'b1; set_val(0, 3); periodic[0] = 1'b0;
    step();
    check_eq("ch0_loaded", 32'(cnt_of(0)), 32'd3);
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (expired[0]) pulses++;
    end
    check_eq("ch0_pulses", 32'(pulses), 32'd1);
    check_eq("ch0_done", 32'(done[0]), 32'd1);
    check_eq("ch0_busy", 32'(busy[0]), 32'd0);

    // ch1 periodic from 2, then abort.
    start[1] = 1'b1; set_val(1, 2); periodic[1] = 1'b1;
    step();
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (expired[1]) pulses++;
      check_eq("ch1_busy", 32'(busy[1]), 32'd1);
    end
    check_eq("ch1_periodic", 32'(pulses >= 2), 32'd1);
    abort[1] = 1'b1;
    step();
    check_eq("ch1_abort_cnt", 32'(cnt_of(1)), 32'd0);
    check_eq("ch1_abort_done", 32'(done[1]), 32'd0);

    // ch2 zero load.
    start[2] = 1'b1; set_val(2, 0);
    step();
    check_eq("ch2_exp", 32'(expired[2]), 32'd1);
    check_eq("ch2_busy", 32'(busy[2]), 32'd0);
    step();
    check_eq("ch2_irq", 32'(irq), 32'd1);
    check_eq("ch2_done", 32'(done[2]), 32'd1);

    // ch3 pause holds count.
    start[3] = 1'b1; set_val(3, 5); periodic[3] = 1'b0;
    step();
    pause[3] = 1'b1;
    for (int k = 0; k < 12; k++) step();
    check_eq("ch3_held", 32'(cnt_of(3)), 32'd5);
    pause[3] = 1'b0;
    for (int k = 0; k < 9; k++) step();
    check_eq("ch3_resumed", 32'(cnt_of(3) < 4'd5), 32'd1);

    // start beats abort; restart mid-count reloads.
    start[0] = 1'b1; abort[0] = 1'b1; set_val(0, 7);
    step();
    check_eq("start_over_abort", 32'(cnt_of(0)), 32'd7);
    for (int k = 0; k < 5; k++) step();
    start[0] = 1'b1; set_val(0, 9);
    step();
    check_eq("restart", 32'(cnt_of(0)), 32'd9);

    // Simultaneous expiry on ch0/ch1.
    abort = '1;
    step();
    start[0] = 1'b1; start[1] = 1'b1; set_val(0, 2); set_val(1, 2);
    periodic[0] = 1'b0; periodic[1] = 1'b0;
    step();
    cap = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (cap == '0 && expired != '0) cap = expired;
    end
    check_eq("sim_expired", 32'(cap), 32'h3);

    // Reset mid-count.
    start[0] = 1'b1; start[1] = 1'b1; set_val(0, 9); set_val(1, 6);
    step();
    step();
    reset = 1'b1;
    #1;
    check_eq("midrst_count", 32'(countdown_out), 32'd0);
    check_eq("midrst_flags", 32'({expired, done, busy, irq}), 32'd0);
    model_reset();
    @(posedge clk_104mhz);
    @(negedge clk_104mhz);
    check_eq("midrst_hold", 32'({countdown_out, expired, irq}), 32'd0);
    reset = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        start[i]    = ($urandom_range(0, 15) == 0);
        abort[i]    = ($urandom_range(0, 31) == 0);
        periodic[i] = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 7) == 0) pause[i] = ~pause[i];
        set_val(i, $urandom_range(0, 15));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
